// File: rtl/uart_cmd_pkg.sv
// -----------------------------------------------------------------------------
// uart_cmd_pkg
// Shared definitions for the UART command frame parser:
//   - parser state encoding
//   - drop-reason codes reported on err_code
//   - legal command codes and the frame length
//   - is_legal_cmd(): membership test for the legal command set
// -----------------------------------------------------------------------------
package uart_cmd_pkg;

    typedef enum logic [2:0] {
        IDLE,
        GET_CMD,
        GET_DHI,
        GET_DLO,
        GET_CHK
    } state_t;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_TIMEOUT = 2'd1;
    localparam logic [1:0] ERR_CHKSUM  = 2'd2;
    localparam logic [1:0] ERR_BADCMD  = 2'd3;

    localparam logic [7:0] CMD_SET_LED    = 8'h01;
    localparam logic [7:0] CMD_CLR_LED    = 8'h02;
    localparam logic [7:0] CMD_TOGGLE_LED = 8'h03;

    // SOF, CMD, DATA_HI, DATA_LO, CHK
    localparam int unsigned FRAME_LEN = 5;

    function automatic logic is_legal_cmd(input logic [7:0] code);
        return (code == CMD_SET_LED) || (code == CMD_CLR_LED) ||
               (code == CMD_TOGGLE_LED);
    endfunction

endpackage

// File: rtl/uart_frame_timeout.sv
// -----------------------------------------------------------------------------
// uart_frame_timeout
// Inter-byte watchdog. Counts enabled cycles since the last clear and flags
// when the count sits at LIMIT-1. The count saturates there, so it never wraps.
//   clk     : system clock
//   rst     : synchronous active-high reset (count -> 0)
//   clr     : synchronous clear (count -> 0), has priority over en
//   en      : count one cycle
//   expired : count == LIMIT-1
// -----------------------------------------------------------------------------
module uart_frame_timeout #(
    parameter int unsigned LIMIT = 50000,
    parameter int unsigned W     = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [W-1:0] LAST = W'(LIMIT - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en && !expired) begin
            cnt <= cnt + W'(1);
        end
    end

    assign expired = (cnt == LAST);

endmodule

// File: rtl/uart_frame_parser.sv
// -----------------------------------------------------------------------------
// uart_frame_parser
// Assembles 5-byte frames {SOF, CMD, DATA_HI, DATA_LO, CHK} from the UART
// receiver byte stream, validates checksum (CHK = CMD^DATA_HI^DATA_LO) and
// command code, and emits one registered command strobe or one error strobe.
//   clk       : system clock
//   rst       : synchronous active-high reset
//   rx_byte   : received byte, sampled when rx_valid=1
//   rx_valid  : one-cycle byte strobe
//   cmd_valid : one-cycle pulse, new cmd_code/cmd_data
//   cmd_code  : last good command code
//   cmd_data  : last good payload {DATA_HI, DATA_LO}
//   frame_err : one-cycle pulse, frame dropped
//   err_code  : drop reason (timeout / checksum / bad command), holds
//   busy      : frame partially received
// -----------------------------------------------------------------------------
module uart_frame_parser
    import uart_cmd_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 50000,
    parameter logic [7:0]  SOF_BYTE       = 8'hA5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_byte,
    input  logic        rx_valid,
    output logic        cmd_valid,
    output logic [7:0]  cmd_code,
    output logic [15:0] cmd_data,
    output logic        frame_err,
    output logic [1:0]  err_code,
    output logic        busy
);

    localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    state_t      state, state_nxt;
    logic [7:0]  cmd_sh, dhi_sh, dlo_sh;
    logic [7:0]  cmd_sh_nxt, dhi_sh_nxt, dlo_sh_nxt;
    logic        cmd_valid_nxt, frame_err_nxt;
    logic [1:0]  err_code_nxt;
    logic [7:0]  cmd_code_nxt;
    logic [15:0] cmd_data_nxt;
    logic        to_expired, to_fire, to_clr, to_en;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cmd_sh    <= '0;
            dhi_sh    <= '0;
            dlo_sh    <= '0;
            cmd_valid <= 1'b0;
            frame_err <= 1'b0;
            err_code  <= ERR_NONE;
            cmd_code  <= '0;
            cmd_data  <= '0;
        end else begin
            state     <= state_nxt;
            cmd_sh    <= cmd_sh_nxt;
            dhi_sh    <= dhi_sh_nxt;
            dlo_sh    <= dlo_sh_nxt;
            cmd_valid <= cmd_valid_nxt;
            frame_err <= frame_err_nxt;
            err_code  <= err_code_nxt;
            cmd_code  <= cmd_code_nxt;
            cmd_data  <= cmd_data_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        cmd_sh_nxt    = cmd_sh;
        dhi_sh_nxt    = dhi_sh;
        dlo_sh_nxt    = dlo_sh;
        cmd_valid_nxt = 1'b0;
        frame_err_nxt = 1'b0;
        err_code_nxt  = err_code;
        cmd_code_nxt  = cmd_code;
        cmd_data_nxt  = cmd_data;
        to_fire       = 1'b0;

        case (state)
            IDLE: begin
                if (rx_valid && (rx_byte == SOF_BYTE)) state_nxt = GET_CMD;
            end
            GET_CMD: begin
                if (rx_valid) begin
                    cmd_sh_nxt = rx_byte;
                    state_nxt  = GET_DHI;
                end
            end
            GET_DHI: begin
                if (rx_valid) begin
                    dhi_sh_nxt = rx_byte;
                    state_nxt  = GET_DLO;
                end
            end
            GET_DLO: begin
                if (rx_valid) begin
                    dlo_sh_nxt = rx_byte;
                    state_nxt  = GET_CHK;
                end
            end
            GET_CHK: begin
                if (rx_valid) begin
                    state_nxt = IDLE;
                    if (rx_byte != (cmd_sh ^ dhi_sh ^ dlo_sh)) begin
                        frame_err_nxt = 1'b1;
                        err_code_nxt  = ERR_CHKSUM;
                    end else if (!is_legal_cmd(cmd_sh)) begin
                        frame_err_nxt = 1'b1;
                        err_code_nxt  = ERR_BADCMD;
                    end else begin
                        cmd_valid_nxt = 1'b1;
                        cmd_code_nxt  = cmd_sh;
                        cmd_data_nxt  = {dhi_sh, dlo_sh};
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase

        // A byte arriving in the expiry cycle wins over the timeout.
        if ((state != IDLE) && !rx_valid && to_expired) begin
            to_fire       = 1'b1;
            state_nxt     = IDLE;
            frame_err_nxt = 1'b1;
            err_code_nxt  = ERR_TIMEOUT;
        end
    end

    // Clearing on the timeout itself keeps the count at 0 throughout IDLE.
    assign to_clr = (state == IDLE) || rx_valid || to_fire;
    assign to_en  = (state != IDLE);
    assign busy   = (state != IDLE);

    uart_frame_timeout #(
        .LIMIT (TIMEOUT_CYCLES),
        .W     (TW)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clr     (to_clr),
        .en      (to_en),
        .expired (to_expired)
    );

endmodule

// File: tb/tb_uart_frame_parser.sv
module tb_uart_frame_parser;

    localparam int unsigned TO  = 16;
    localparam logic [7:0]  SOF = 8'hA5;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_byte;
    logic        rx_valid;
    logic        cmd_valid;
    logic [7:0]  cmd_code;
    logic [15:0] cmd_data;
    logic        frame_err;
    logic [1:0]  err_code;
    logic        busy;

    uart_frame_parser #(
        .TIMEOUT_CYCLES (TO),
        .SOF_BYTE       (SOF)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_byte   (rx_byte),
        .rx_valid  (rx_valid),
        .cmd_valid (cmd_valid),
        .cmd_code  (cmd_code),
        .cmd_data  (cmd_data),
        .frame_err (frame_err),
        .err_code  (err_code),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int edge_no = 0;
    always @(posedge clk) edge_no <= edge_no + 1;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int          cyc;
        bit          is_err;
        logic [1:0]  ec;
        logic [7:0]  code;
        logic [15:0] data;
    } exp_t;

    exp_t        q[$];
    bit          exp_busy[int];
    int          reset_edge = -1;

    // Reference model: frame-level view of the byte stream.
    bit          in_frame = 1'b0;
    logic [7:0]  fb[$];
    int          idle_cnt = 0;
    logic [7:0]  good_code = '0;
    logic [15:0] good_data = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_no);
        end
    endtask

    function automatic void push_evt(input int e, input bit is_err, input logic [1:0] ec);
        exp_t x;
        x.cyc    = e;
        x.is_err = is_err;
        x.ec     = ec;
        x.code   = good_code;
        x.data   = good_data;
        q.push_back(x);
    endfunction

    // e is the number of the clock edge that samples this input.
    function automatic void model_step(input bit v, input logic [7:0] b, input int e);
        if (in_frame) begin
            if (v) begin
                idle_cnt = 0;
                fb.push_back(b);
                if (fb.size() == 4) begin
                    in_frame = 1'b0;
                    if ((fb[0] ^ fb[1] ^ fb[2]) != fb[3]) begin
                        push_evt(e, 1'b1, 2'd2);
                    end else if (fb[0] inside {8'h01, 8'h02, 8'h03}) begin
                        good_code = fb[0];
                        good_data = {fb[1], fb[2]};
                        push_evt(e, 1'b0, 2'd0);
                    end else begin
                        push_evt(e, 1'b1, 2'd3);
                    end
                end
            end else begin
                idle_cnt++;
                if (idle_cnt == TO) begin
                    in_frame = 1'b0;
                    push_evt(e, 1'b1, 2'd1);
                end
            end
        end else if (v && (b == SOF)) begin
            in_frame = 1'b1;
            fb.delete();
            idle_cnt = 0;
        end
        exp_busy[e] = in_frame;
    endfunction

    task automatic step(input bit v, input logic [7:0] b);
        @(negedge clk);
        rst      = 1'b0;
        rx_valid = v;
        rx_byte  = v ? b : 8'($urandom);
        model_step(v, b, edge_no + 1);
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 8'h00);
    endtask

    task automatic send_bytes(input logic [63:0] f, input int n);
        for (int i = 0; i < n; i++) step(1'b1, f[(n-1-i)*8 +: 8]);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_byte  = 8'($urandom);
        in_frame  = 1'b0;
        fb.delete();
        idle_cnt  = 0;
        good_code = '0;
        good_data = '0;
        reset_edge = edge_no + 1;
        exp_busy[edge_no + 1] = 1'b0;
    endtask

    // Monitor: compare whatever the DUT shows after each edge.
    exp_t mon_e;
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc < edge_no) begin
            chk("event_missed_at_edge", edge_no, q[0].cyc);
            void'(q.pop_front());
        end
        if (edge_no == reset_edge) begin
            chk("rst_cmd_valid", cmd_valid, 0);
            chk("rst_frame_err", frame_err, 0);
            chk("rst_cmd_code", cmd_code, 0);
            chk("rst_cmd_data", cmd_data, 0);
            chk("rst_err_code", err_code, 0);
        end
        if (exp_busy.exists(edge_no)) chk("busy", busy, exp_busy[edge_no]);
        if (cmd_valid === 1'b1 || frame_err === 1'b1) begin
            chk("valid_err_exclusive", cmd_valid & frame_err, 0);
            chk("output_expected", q.size() > 0, 1);
            if (q.size() > 0) begin
                mon_e = q.pop_front();
                chk("event_edge", edge_no, mon_e.cyc);
                chk("frame_err", frame_err, mon_e.is_err);
                chk("cmd_valid", cmd_valid, !mon_e.is_err);
                if (mon_e.is_err) chk("err_code", err_code, mon_e.ec);
                chk("cmd_code", cmd_code, mon_e.code);
                chk("cmd_data", cmd_data, mon_e.data);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, edge %0d", edge_no);
        $fatal(1);
    end

    initial begin
        logic [7:0] c, dh, dl, ck, g;
        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_byte  = 8'h00;
        do_reset();
        do_reset();
        idle(2);

        // Good frame
        send_bytes(64'hA5_01_03_FF_FD, 5);
        idle(3);
        // Bad checksum
        send_bytes(64'hA5_02_00_10_00, 5);
        idle(3);
        // Bad command, then garbage before a good frame
        send_bytes(64'hA5_7E_00_00_7E, 5);
        idle(2);
        send_bytes(64'h00_FF_5A_A5_03_00_01_02, 8);
        idle(3);
        // Timeout, then a byte arriving just before expiry
        send_bytes(64'hA5_01, 2);
        idle(20);
        send_bytes(64'hA5_01, 2);
        idle(TO - 1);
        send_bytes(64'h03_FF_FD, 3);
        idle(3);
        // Reset mid-frame
        send_bytes(64'hA5_01_03, 3);
        do_reset();
        send_bytes(64'hA5_01_03_FF_FD, 5);
        idle(3);
        // Back-to-back frames
        send_bytes(64'hA5_01_00_0F_0E, 5);
        send_bytes(64'hA5_02_F0_00_F2, 5);
        idle(3);

        // Randomized frames: good, corrupted, illegal commands, garbage, gaps
        for (int k = 0; k < 200; k++) begin
            if ($urandom_range(0, 3) == 0) begin
                g = 8'($urandom);
                if (g == SOF) g = 8'h00;
                step(1'b1, g);
            end
            idle($urandom_range(0, 2));
            c  = ($urandom_range(0, 4) == 0) ? 8'($urandom) : 8'($urandom_range(1, 3));
            dh = ($urandom_range(0, 7) == 0) ? SOF : 8'($urandom);
            dl = 8'($urandom);
            ck = c ^ dh ^ dl;
            if ($urandom_range(0, 5) == 0) ck = ck ^ 8'($urandom_range(1, 255));
            step(1'b1, SOF);
            for (int i = 0; i < 4; i++) begin
                int r;
                r = $urandom_range(0, 19);
                if (r >= 18)      idle($urandom_range(TO - 2, TO + 1));
                else if (r >= 15) idle($urandom_range(1, 3));
                case (i)
                    0: step(1'b1, c);
                    1: step(1'b1, dh);
                    2: step(1'b1, dl);
                    default: step(1'b1, ck);
                endcase
            end
        end

        idle(TO + 9);
        chk("scoreboard_drained", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
